// File: rtl/router_pkt_tx.sv
// Packet source for the 3-port router ingress: buffers a commanded payload, then
// frames it as header, payload beats and a trailing (optionally corrupted) parity beat.
module router_pkt_tx #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int MAX_LEN = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-ADDR_W-1:0] cmd_len,
  input  logic                     cmd_bad_par,
  output logic                     cmd_err,
  input  logic                     pl_valid,
  input  logic [DATA_W-1:0]        pl_data,
  output logic                     pl_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic                     pkt_valid,
  input  logic                     busy,
  output logic                     tx_active,
  output logic                     pkt_sent
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO_L    = LEN_W'(0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  function automatic logic [DATA_W-1:0] par_fold(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] beat);
    return acc ^ beat;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic               r_bad_par, w_bad_par_nxt;
  logic [LEN_W-1:0]   r_wr_cnt, w_wr_cnt_nxt;
  logic [LEN_W-1:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic [DATA_W-1:0]  r_parity, w_parity_nxt;
  logic [DATA_W-1:0]  r_data_out, w_data_out_nxt;
  logic               r_pkt_valid, w_pkt_valid_nxt;
  logic               r_cmd_err, w_cmd_err_nxt;
  logic               r_pkt_sent, w_pkt_sent_nxt;
  logic               r_tx_active;
  logic [DATA_W-1:0]  r_buf [MAX_LEN];

  logic               w_cmd_fire, w_pl_fire, w_len_ok;
  logic [LEN_W-1:0]   w_wr_inc, w_rd_inc;
  logic [DATA_W-1:0]  w_par_acc;

  // Handshake readies drop in the reset cycle so nothing is accepted while reset is high.
  assign cmd_ready  = (r_state == S_IDLE) && !reset;
  assign pl_ready   = (r_state == S_LOAD) && !reset;
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_pl_fire  = pl_valid && pl_ready;
  assign w_len_ok   = (cmd_len != ZERO_L) && (cmd_len <= MAX_LEN_L);
  assign w_wr_inc   = r_wr_cnt + ONE_L;
  assign w_rd_inc   = r_rd_cnt + ONE_L;
  assign w_par_acc  = par_fold(r_parity, r_data_out);

  assign data_out  = r_data_out;
  assign pkt_valid = r_pkt_valid;
  assign cmd_err   = r_cmd_err;
  assign pkt_sent  = r_pkt_sent;
  assign tx_active = r_tx_active;

  // Next-state and next-output decode; a wire beat advances only when busy is low.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_len_nxt       = r_len;
    w_bad_par_nxt   = r_bad_par;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_parity_nxt    = r_parity;
    w_data_out_nxt  = r_data_out;
    w_pkt_valid_nxt = r_pkt_valid;
    w_cmd_err_nxt   = 1'b0;
    w_pkt_sent_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_data_out_nxt  = {DATA_W{1'b0}};
        w_pkt_valid_nxt = 1'b0;
        if (w_cmd_fire && w_len_ok) begin
          w_addr_nxt    = cmd_addr;
          w_len_nxt     = cmd_len;
          w_bad_par_nxt = cmd_bad_par;
          w_wr_cnt_nxt  = ZERO_L;
          w_state_nxt   = S_LOAD;
        end else if (w_cmd_fire) begin
          w_cmd_err_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_pl_fire) begin
          w_wr_cnt_nxt = w_wr_inc;
          if (w_wr_inc == r_len) begin
            w_data_out_nxt  = {r_len, r_addr};
            w_pkt_valid_nxt = 1'b1;
            w_state_nxt     = S_HEADER;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_HEADER: begin
        if (!busy) begin
          w_parity_nxt   = r_data_out;
          w_rd_cnt_nxt   = ZERO_L;
          w_data_out_nxt = r_buf[{IDX_W{1'b0}}];
          w_state_nxt    = S_PAYLOAD;
        end else begin
          w_state_nxt = S_HEADER;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          w_parity_nxt = w_par_acc;
          w_rd_cnt_nxt = w_rd_inc;
          if (w_rd_inc == r_len) begin
            w_data_out_nxt  = w_par_acc ^ {DATA_W{r_bad_par}};
            w_pkt_valid_nxt = 1'b0;
            w_state_nxt     = S_PARITY;
          end else begin
            w_data_out_nxt = r_buf[w_rd_inc[IDX_W-1:0]];
          end
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PARITY: begin
        if (!busy) begin
          w_pkt_sent_nxt = 1'b1;
          w_data_out_nxt = {DATA_W{1'b0}};
          w_state_nxt    = S_GAP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_data_out_nxt  = {DATA_W{1'b0}};
        w_pkt_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, parity accumulator and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_len       <= ZERO_L;
      r_bad_par   <= 1'b0;
      r_wr_cnt    <= ZERO_L;
      r_rd_cnt    <= ZERO_L;
      r_parity    <= {DATA_W{1'b0}};
      r_data_out  <= {DATA_W{1'b0}};
      r_pkt_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_pkt_sent  <= 1'b0;
      r_tx_active <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_len       <= w_len_nxt;
      r_bad_par   <= w_bad_par_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_parity    <= w_parity_nxt;
      r_data_out  <= w_data_out_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
      r_pkt_sent  <= w_pkt_sent_nxt;
      r_tx_active <= (w_state_nxt != S_IDLE);
    end
  end

  // Payload buffer; contents are left untouched by reset.
  always_ff @(posedge clock) begin
    if (w_pl_fire) begin
      r_buf[r_wr_cnt[IDX_W-1:0]] <= pl_data;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a queue-based packet model checked every cycle,
// plus directed packets whose wire beats are pinned to hand-computed values.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_addr = 2'd0;
  logic [5:0] cmd_len = 6'd0;
  logic       cmd_bad_par = 1'b0;
  logic       cmd_err;
  logic       pl_valid = 1'b0;
  logic [7:0] pl_data = 8'h00;
  logic       pl_ready;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       busy = 1'b0;
  logic       tx_active;
  logic       pkt_sent;

  router_pkt_tx #(.DATA_W(8), .ADDR_W(2), .MAX_LEN(16)) dut (
    .clock(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_bad_par(cmd_bad_par), .cmd_err(cmd_err),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .data_out(data_out), .pkt_valid(pkt_valid), .busy(busy),
    .tx_active(tx_active), .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic void chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Model: 0 idle, 1 collecting payload, 2 beats on the wire, 3 post-packet gap.
  typedef struct packed { logic [7:0] d; logic v; } beat_t;
  beat_t      wq[$];
  logic [7:0] plq[$];
  int         m_mode = 0;
  logic [1:0] m_addr;
  int         m_len;
  bit         m_bad;
  bit         e_err = 1'b0;
  bit         e_sent = 1'b0;
  bit         started = 1'b0;

  initial begin
    logic [7:0] x;
    forever begin
      @(posedge clk);
      if (reset) begin
        started = 1'b1;
        m_mode = 0; wq.delete(); plq.delete(); e_err = 1'b0; e_sent = 1'b0;
      end else begin
        e_err = 1'b0; e_sent = 1'b0;
        case (m_mode)
          0: if (cmd_valid) begin
               if (cmd_len >= 1 && cmd_len <= 16) begin
                 m_addr = cmd_addr; m_len = int'(cmd_len); m_bad = cmd_bad_par;
                 plq.delete(); m_mode = 1;
               end else e_err = 1'b1;
             end
          1: if (pl_valid) begin
               plq.push_back(pl_data);
               if (plq.size() == m_len) begin
                 x = {m_len[5:0], m_addr};
                 wq.push_back({x, 1'b1});
                 foreach (plq[i]) begin
                   wq.push_back({plq[i], 1'b1});
                   x = x ^ plq[i];
                 end
                 wq.push_back({m_bad ? ~x : x, 1'b0});
                 m_mode = 2;
               end
             end
          2: if (!busy) begin
               void'(wq.pop_front());
               if (wq.size() == 0) begin e_sent = 1'b1; m_mode = 3; end
             end
          default: m_mode = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_data",   data_out,  (m_mode == 2) ? wq[0].d : 8'h00);
        chk("m_valid",  {7'd0, pkt_valid}, {7'd0, (m_mode == 2) ? wq[0].v : 1'b0});
        chk("m_cmdrdy", {7'd0, cmd_ready}, {7'd0, (m_mode == 0) && !reset});
        chk("m_plrdy",  {7'd0, pl_ready},  {7'd0, (m_mode == 1) && !reset});
        chk("m_active", {7'd0, tx_active}, {7'd0, m_mode != 0});
        chk("m_err",    {7'd0, cmd_err},   {7'd0, e_err});
        chk("m_sent",   {7'd0, pkt_sent},  {7'd0, e_sent});
      end
    end
  end

  logic [7:0] stim_q[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l, input logic bp);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_bad_par = bp;
    tick();
    cmd_valid = 1'b0;
    foreach (stim_q[i]) begin
      pl_valid = 1'b1; pl_data = stim_q[i];
      tick();
    end
    pl_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [7:0] d, input logic v,
                     input logic s, input logic rdy);
    @(negedge clk);
    chk({nm, "_data"}, data_out, d);
    chk({nm, "_valid"}, {7'd0, pkt_valid}, {7'd0, v});
    chk({nm, "_sent"}, {7'd0, pkt_sent}, {7'd0, s});
    chk({nm, "_rdy"}, {7'd0, cmd_ready}, {7'd0, rdy});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    tick(); tick();
    reset = 1'b0;
    lit("rst", 8'h00, 1'b0, 1'b0, 1'b1);

    // Basic packet: addr 1, payload A5 3C 0F.
    stim_q = '{8'hA5, 8'h3C, 8'h0F};
    send(2'd1, 6'd3, 1'b0);
    lit("t1_hdr", 8'h0D, 1'b1, 1'b0, 1'b0);
    lit("t1_p0",  8'hA5, 1'b1, 1'b0, 1'b0);
    lit("t1_p1",  8'h3C, 1'b1, 1'b0, 1'b0);
    lit("t1_p2",  8'h0F, 1'b1, 1'b0, 1'b0);
    lit("t1_par", 8'h9B, 1'b0, 1'b0, 1'b0);
    lit("t1_snt", 8'h00, 1'b0, 1'b1, 1'b0);
    lit("t1_idl", 8'h00, 1'b0, 1'b0, 1'b1);

    // Corrupted parity.
    send(2'd1, 6'd3, 1'b1);
    lit("t2_hdr", 8'h0D, 1'b1, 1'b0, 1'b0);
    lit("t2_p0",  8'hA5, 1'b1, 1'b0, 1'b0);
    lit("t2_p1",  8'h3C, 1'b1, 1'b0, 1'b0);
    lit("t2_p2",  8'h0F, 1'b1, 1'b0, 1'b0);
    lit("t2_par", 8'h64, 1'b0, 1'b0, 1'b0);
    lit("t2_snt", 8'h00, 1'b0, 1'b1, 1'b0);
    lit("t2_idl", 8'h00, 1'b0, 1'b0, 1'b1);

    // Back-pressure on a payload beat, then on the parity beat.
    send(2'd1, 6'd3, 1'b0);
    lit("t3_hdr", 8'h0D, 1'b1, 1'b0, 1'b0);
    lit("t3_p0",  8'hA5, 1'b1, 1'b0, 1'b0);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) lit("t3_hold", 8'h3C, 1'b1, 1'b0, 1'b0);
    busy = 1'b0;
    lit("t3_p1",  8'h3C, 1'b1, 1'b0, 1'b0);
    lit("t3_p2",  8'h0F, 1'b1, 1'b0, 1'b0);
    busy = 1'b1;
    lit("t4_parh", 8'h9B, 1'b0, 1'b0, 1'b0);
    lit("t4_parh", 8'h9B, 1'b0, 1'b0, 1'b0);
    busy = 1'b0;
    lit("t4_par", 8'h9B, 1'b0, 1'b0, 1'b0);
    lit("t4_snt", 8'h00, 1'b0, 1'b1, 1'b0);
    lit("t4_idl", 8'h00, 1'b0, 1'b0, 1'b1);

    // Rejected lengths, with stray payload offered while idle.
    pl_valid = 1'b1; pl_data = 8'h55;
    cmd_valid = 1'b1; cmd_len = 6'd0; cmd_addr = 2'd2;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_err0", {7'd0, cmd_err}, 8'd1);
    chk("t5_act0", {7'd0, tx_active}, 8'd0);
    tick();
    @(negedge clk);
    chk("t5_once0", {7'd0, cmd_err}, 8'd0);
    cmd_valid = 1'b1; cmd_len = 6'd17;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_err17", {7'd0, cmd_err}, 8'd1);
    chk("t5_pv17", {7'd0, pkt_valid}, 8'd0);
    tick();
    @(negedge clk);
    chk("t5_once17", {7'd0, cmd_err}, 8'd0);
    tick();
    pl_valid = 1'b0;

    // Max length to address 3 with periodic busy.
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'(i * 17 + 3));
    send(2'd3, 6'd16, 1'b0);
    lit("t6_hdr", 8'h43, 1'b1, 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      busy = (i % 3 == 1);
      @(negedge clk);
      if (!tx_active) done = 1'b1;
      tick();
    end
    busy = 1'b0;
    chk("t6_drain", {7'd0, done}, 8'd1);

    // Reset in the middle of a packet, then a fresh one-beat packet.
    stim_q = '{8'hA5, 8'h3C, 8'h0F};
    send(2'd1, 6'd3, 1'b0);
    lit("t7_hdr", 8'h0D, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_rdy_in_rst", {7'd0, cmd_ready}, 8'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t7_pv", {7'd0, pkt_valid}, 8'd0);
    chk("t7_do", data_out, 8'h00);
    chk("t7_act", {7'd0, tx_active}, 8'd0);
    chk("t7_rdy", {7'd0, cmd_ready}, 8'd1);
    tick();
    stim_q = '{8'hFF};
    send(2'd2, 6'd1, 1'b0);
    lit("t8_hdr", 8'h06, 1'b1, 1'b0, 1'b0);
    lit("t8_p0",  8'hFF, 1'b1, 1'b0, 1'b0);
    lit("t8_par", 8'hF9, 1'b0, 1'b0, 1'b0);
    lit("t8_snt", 8'h00, 1'b0, 1'b1, 1'b0);
    lit("t8_idl", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
